// File: rtl/imem_loader.sv
// Purpose: byte-stream program loader that assembles 16-bit words (high byte first) into instruction memory.
// Latency: one word write 3 cycles after its high byte is offered; done/error the cycle after the checksum byte.
// Backpressure: rx_ready decodes from state only, low in IDLE/WRITE/DONE/ERR; rx_valid gaps stall with no timeout.
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr;       // word currently being assembled
  logic [AW-1:0] last_addr;  // N-1, the final word address of this frame
  logic [7:0]    sum;        // running modulo-256 sum of data bytes
  logic [7:0]    hi_byte;
  logic          xfer;
  logic          count_bad;

  // Byte-accepting states; decoded from state alone so rx_valid never reaches rx_ready.
  assign rx_ready  = (state == S_COUNT) || (state == S_HI) ||
                     (state == S_LO)    || (state == S_CSUM);
  assign xfer      = rx_valid && rx_ready;
  assign count_bad = (rx_data == 8'd0) || (rx_data > DEPTH_B);

  // State register; reset lands in IDLE immediately, even mid-load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded status outputs.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_COUNT;
      end
      S_COUNT: begin
        busy = 1'b1;
        if (xfer) state_nxt = count_bad ? S_ERR : S_HI;
      end
      S_HI: begin
        busy = 1'b1;
        if (xfer) state_nxt = S_LO;
      end
      S_LO: begin
        busy = 1'b1;
        if (xfer) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        state_nxt = (addr == last_addr) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        busy = 1'b1;
        if (xfer) state_nxt = (rx_data == sum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) state_nxt = S_COUNT;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_nxt = S_COUNT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame datapath: count, byte assembly, checksum and the registered write port.
  // The write port is loaded as the low byte arrives so it is stable during WRITE
  // and simply holds afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      last_addr <= '0;
      sum       <= 8'd0;
      hi_byte   <= 8'd0;
      mem_addr  <= '0;
      mem_wdata <= 16'd0;
    end else begin
      case (state)
        S_COUNT: begin
          if (xfer && !count_bad) begin
            addr      <= '0;
            sum       <= 8'd0;
            last_addr <= AW'(rx_data - 8'd1);
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_byte <= rx_data;
            sum     <= sum + rx_data;
          end
        end
        S_LO: begin
          if (xfer) begin
            sum       <= sum + rx_data;
            mem_wdata <= {hi_byte, rx_data};
            mem_addr  <= addr;
          end
        end
        S_WRITE: begin
          if (addr != last_addr) addr <= addr + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames, scoreboarded memory writes and end-of-load status.
// Stimulus drives 1 time unit after the rising edge; the monitor samples on the falling edge.
// Expected writes and final status are queued by the stimulus and retired by the monitor.
module tb_imem_loader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  logic [AW+15:0] exp_wr[$];  // {addr, data}
  logic [2:0]     exp_st[$];  // {done, error, cpu_reset} once busy drops
  logic           prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: retire each memory write and each end-of-load status against the queues.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_count++;
      if (exp_wr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %0h@%0h, expected no write", mem_wdata, mem_addr);
      end else begin
        check("mem_write", {mem_addr, mem_wdata}, exp_wr.pop_front());
      end
    end
    if (prev_busy && !busy) begin
      if (exp_st.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_status: got %0b, expected none", {done, error, cpu_reset});
      end else begin
        check("end_status", {done, error, cpu_reset}, exp_st.pop_front());
      end
    end
    prev_busy = busy;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte and hold it until a rising edge with rx_ready high consumes it.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    logic r;
    int   waited;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    forever begin
      r = rx_ready;
      @(posedge clk); #1;
      if (r) break;
      waited++;
      if (waited > 100) begin
        tests++;
        fails++;
        $display("FAIL byte_timeout: byte %0h not accepted, expected accept within 100 cycles", b);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_good_frame(input bit stall);
    exp_wr.push_back({4'd0, 16'h1234});
    exp_wr.push_back({4'd1, 16'hABCD});
    exp_st.push_back(3'b100);
    send_byte(8'h02, stall);
    send_byte(8'h12, stall);
    send_byte(8'h34, stall);
    send_byte(8'hAB, stall);
    send_byte(8'hCD, stall);
    send_byte(8'hBE, stall);
  endtask

  initial begin
    int n0;
    #2;
    check("rst_rx_ready",  rx_ready,  0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    check("rst_error",     error,     0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Good load
    n0 = wr_count;
    pulse_start();
    check("good_busy", busy, 1);
    send_good_frame(1'b0);
    check("good_done",      done,      1);
    check("good_error",     error,     0);
    check("good_cpu_reset", cpu_reset, 0);
    check("good_writes",    wr_count - n0, 2);

    // Bad checksum: writes still happen, then error
    n0 = wr_count;
    pulse_start();
    check("restart_cpu_reset", cpu_reset, 1);
    check("restart_done",      done,      0);
    exp_wr.push_back({4'd0, 16'h1234});
    exp_wr.push_back({4'd1, 16'hABCD});
    exp_st.push_back(3'b011);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'hBF, 1'b0);
    check("badsum_error",     error,     1);
    check("badsum_done",      done,      0);
    check("badsum_cpu_reset", cpu_reset, 1);
    check("badsum_writes",    wr_count - n0, 2);

    // Bad counts: 0 and 17
    n0 = wr_count;
    pulse_start();
    exp_st.push_back(3'b011);
    send_byte(8'h00, 1'b0);
    check("cnt0_error", error, 1);
    pulse_start();
    exp_st.push_back(3'b011);
    send_byte(8'h11, 1'b0);
    check("cnt17_error", error, 1);
    check("badcnt_writes", wr_count - n0, 0);

    // Full depth with random rx_valid gaps; checksum 0..15 summed = 0x78
    n0 = wr_count;
    pulse_start();
    exp_st.push_back(3'b100);
    send_byte(8'h10, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      exp_wr.push_back({4'(i), 8'(i), 8'h00});
      send_byte(8'(i), 1'b1);
      send_byte(8'h00, 1'b1);
    end
    send_byte(8'h78, 1'b1);
    check("full_done",   done, 1);
    check("full_writes", wr_count - n0, 16);

    // Reset during LO of word 1
    pulse_start();
    exp_wr.push_back({4'd0, 16'h1234});
    exp_st.push_back(3'b001);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_rx_ready",  rx_ready,  0);
    check("midrst_mem_we",    mem_we,    0);
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_busy",      busy,      0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    send_good_frame(1'b1);
    check("postrst_done", done, 1);

    // start while busy is ignored
    pulse_start();
    exp_wr.push_back({4'd0, 16'h1234});
    exp_wr.push_back({4'd1, 16'hABCD});
    exp_st.push_back(3'b100);
    send_byte(8'h02, 1'b0);
    pulse_start();
    check("busystart_busy",     busy,     1);
    check("busystart_rx_ready", rx_ready, 1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'hBE, 1'b0);
    check("busystart_done", done, 1);
    pulse_start();
    check("after_done_cpu_reset", cpu_reset, 1);
    check("after_done_done",      done,      0);
    check("after_done_busy",      busy,      1);
    exp_st.push_back(3'b011);
    send_byte(8'h00, 1'b0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    check("writes_left", exp_wr.size(), 0);
    check("status_left", exp_st.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
